// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared types and constants for the sequential multiply/divide
//            unit: operation encoding, FSM states and datapath sizing.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq_if
// Purpose  : Request/result bundle between the pipeline and the MDU.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_seq_if;
    import mdu_pkg::*;

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_step
// Purpose  : One radix-2 iteration: shift-add multiply or restoring divide.
//            {acc_hi, acc_lo} is the working register; opnd_i is the
//            multiplicand or divisor magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_step
    import mdu_pkg::*;
(
    input  wire logic             is_div_i,
    input  wire logic [WIDTH-1:0] acc_hi_i,
    input  wire logic [WIDTH-1:0] acc_lo_i,
    input  wire logic [WIDTH-1:0] opnd_i,
    output logic      [WIDTH-1:0] acc_hi_o,
    output logic      [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Single iteration; the divide relies on acc_hi < divisor, so bit 32 of
    // the difference is a clean borrow flag.
    always_comb begin
        w_sum    = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
        w_rem_sh = {acc_hi_i, acc_lo_i[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, opnd_i};
        w_ge     = ~w_diff[WIDTH];
        if (is_div_i) begin
            acc_hi_o = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            acc_lo_o = {acc_lo_i[WIDTH-2:0], w_ge};
        end else begin
            acc_hi_o = w_sum[WIDTH:1];
            acc_lo_o = {w_sum[0], acc_lo_i[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Purpose  : Sequential 32x32 multiply / 32/32 divide unit with HI/LO
//            result registers. 32 iteration cycles plus one sign-fix cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_seq
    import mdu_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    mdu_seq_if.slave   bus
);

    localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

    state_e           state_q,  state_d;
    op_e              op_q,     op_d;
    logic [WIDTH-1:0] opnd_q,   opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [4:0]       cnt_q,    cnt_d;
    logic             negq_q,   negq_d;
    logic             negr_q,   negr_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             done_q,   done_d;
    logic             dbz_q,    dbz_d;

    op_e              w_op_in;
    logic             w_sa, w_sb;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH-1:0] w_step_hi, w_step_lo;
    logic [2*WIDTH-1:0] w_prod;

    mdu_step u_step (
        .is_div_i (op_is_div(op_q)),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opnd_i   (opnd_q),
        .acc_hi_o (w_step_hi),
        .acc_lo_o (w_step_lo)
    );

    // Next-state and datapath control for IDLE / CALC / FIX.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        w_op_in = op_e'(bus.op);
        w_sa    = op_is_signed(w_op_in) & bus.a[WIDTH-1];
        w_sb    = op_is_signed(w_op_in) & bus.b[WIDTH-1];
        w_mag_a = w_sa ? (~bus.a + 1'b1) : bus.a;
        w_mag_b = w_sb ? (~bus.b + 1'b1) : bus.b;
        w_prod  = {acc_hi_q, acc_lo_q};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (op_is_div(w_op_in) && (bus.b == '0)) begin
                        // Divide by zero completes at once, HI/LO untouched.
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        state_d  = ST_CALC;
                        op_d     = w_op_in;
                        cnt_d    = '0;
                        negq_d   = w_sa ^ w_sb;
                        negr_d   = w_sa;
                        acc_hi_d = '0;
                        if (op_is_div(w_op_in)) begin
                            acc_lo_d = w_mag_a;
                            opnd_d   = w_mag_b;
                        end else begin
                            acc_lo_d = w_mag_b;
                            opnd_d   = w_mag_a;
                        end
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            ST_CALC: begin
                acc_hi_d = w_step_hi;
                acc_lo_d = w_step_lo;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (op_is_div(op_q)) begin
                    lo_d = negq_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                    hi_d = negr_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
                end else begin
                    if (negq_q) w_prod = ~w_prod + 1'b1;
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_seq
// Purpose  : Directed, table-driven bench for mdu_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    mdu_seq_if bus ();

    mdu_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; leaves time at posedge+1 after the start edge.
    task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic cycle;
        @(posedge clk); #1;
    endtask

    initial begin
        int  lat;
        bit  bok;
        bit  seen;

        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 33};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[5] = '{OP_MULT,  32'h00012345, 32'h00010000, 32'h00000001, 32'h23450000, 1'b0, 33};
        vecs[6] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 33};
        vecs[7] = '{OP_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33};
        vecs[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
        vecs[9] = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 33};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
        chk("rst_hi",   bus.hi, 32'd0);
        chk("rst_lo",   bus.lo, 32'd0);
        rst = 1'b0;
        cycle();

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bok);
            chk($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), {31'd0, bok}, 32'd1);
            chk($sformatf("v%0d_idle", i), {31'd0, bus.busy}, 32'd0);
            chk($sformatf("v%0d_hi", i),   bus.hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i),   bus.lo, vecs[i].lo);
            chk($sformatf("v%0d_dbz", i),  {31'd0, bus.div_by_zero}, {31'd0, vecs[i].dbz});
            cycle();
            chk($sformatf("v%0d_pulse", i), {31'd0, bus.done}, 32'd0);
        end

        // Back-to-back: new start on the done cycle is accepted
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(lat, bok);
        chk("b2b_hi1", bus.hi, 32'hFFFFFFFF);
        chk("b2b_lo1", bus.lo, 32'hFFFFFFF1);
        issue(OP_DIVU, 32'd7, 32'd2);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(lat, bok);
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("b2b_hi2", bus.hi, 32'd1);
        chk("b2b_lo2", bus.lo, 32'd3);
        cycle();

        // mtlo in IDLE, mthi while busy
        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        cycle();
        bus.lo_we = 1'b0;
        chk("mtlo", bus.lo, 32'h1234);
        issue(OP_MULTU, 32'd2, 32'd3);
        repeat (4) cycle();
        bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        cycle();
        bus.hi_we = 1'b0;
        wait_done(lat, bok);
        chk("mthi_busy_hi", bus.hi, 32'd0);
        chk("mthi_busy_lo", bus.lo, 32'd6);
        cycle();

        // Direct write together with start is ignored
        bus.hi_we = 1'b1; bus.wdata = 32'hCAFE0000;
        issue(OP_MULTU, 32'd4, 32'd4);
        bus.hi_we = 1'b0;
        wait_done(lat, bok);
        chk("we_start_hi", bus.hi, 32'd0);
        chk("we_start_lo", bus.lo, 32'd16);
        cycle();

        // Both writes at once
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
        cycle();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("both_hi", bus.hi, 32'hA5A5A5A5);
        chk("both_lo", bus.lo, 32'hA5A5A5A5);

        // Divide by zero leaves HI/LO intact
        bus.hi_we = 1'b1; bus.wdata = 32'h11;
        cycle();
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22;
        cycle();
        bus.lo_we = 1'b0;
        issue(OP_DIVU, 32'd5, 32'd0);
        chk("dbz_done", {31'd0, bus.done}, 32'd1);
        chk("dbz_flag", {31'd0, bus.div_by_zero}, 32'd1);
        chk("dbz_busy", {31'd0, bus.busy}, 32'd0);
        chk("dbz_hi", bus.hi, 32'h11);
        chk("dbz_lo", bus.lo, 32'h22);
        cycle();
        chk("dbz_pulse_done", {31'd0, bus.done}, 32'd0);
        chk("dbz_pulse_flag", {31'd0, bus.div_by_zero}, 32'd0);

        // Start in mid-CALC is ignored
        issue(OP_DIVU, 32'hFFFFFFFF, 32'h10);
        repeat (15) cycle();
        issue(OP_MULTU, 32'd3, 32'd3);
        wait_done(lat, bok);
        chk("mid_lat", 32'(lat), 32'd17);
        chk("mid_hi", bus.hi, 32'h0000000F);
        chk("mid_lo", bus.lo, 32'h0FFFFFFF);
        cycle();
        chk("mid_nosecond", {31'd0, bus.busy}, 32'd0);

        // Reset mid-operation
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        repeat (9) cycle();
        rst = 1'b1;
        #1;
        chk("amid_busy", {31'd0, bus.busy}, 32'd0);
        chk("amid_hi", bus.hi, 32'd0);
        chk("amid_lo", bus.lo, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            cycle();
        end
        chk("amid_nodone", {31'd0, seen}, 32'd0);

        // First start after reset
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_done(lat, bok);
        chk("post_lat", 32'(lat), 32'd33);
        chk("post_hi", bus.hi, 32'd1);
        chk("post_lo", bus.lo, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, named rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  operation request, sampled on the rising edge of clk.
REQ-005 op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 a  input  32  first operand (multiplicand or dividend).
REQ-007 b  input  32  second operand (multiplier or divisor).
REQ-008 hi_we  input  1  direct HI write (mthi).
REQ-009 lo_we  input  1  direct LO write (mtlo).
REQ-010 wdata  input  32  data for hi_we and lo_we.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when the HI/LO result is valid.
REQ-013 div_by_zero  output  1  one-cycle pulse, coincident with done, when a divide had b==0.
REQ-014 hi  output  32  HI register.
REQ-015 lo  output  32  LO register.

Function
REQ-016 States SHALL be IDLE, CALC and FIX; busy SHALL be 1 exactly when the state is not IDLE.
REQ-017 In IDLE, start=1 SHALL latch op, a and b, and move the block to CALC with the iteration count at 0.
REQ-018 For signed ops, start SHALL latch operand magnitudes and record the result signs: product/quotient sign = a[31]^b[31], remainder sign = a[31].
REQ-019 CALC SHALL perform one radix-2 step per cycle for exactly 32 cycles: shift-add for multiply, restoring subtract-shift for divide.
REQ-020 After the 32nd step, CALC SHALL move to FIX.
REQ-021 FIX SHALL apply two's-complement sign correction in one cycle, write HI/LO, and return to IDLE.
REQ-022 Multiply SHALL write HI=product[63:32] and LO=product[31:0].
REQ-023 Divide SHALL write LO=quotient and HI=remainder.
REQ-024 done SHALL be a registered pulse, high in the cycle after the FIX edge, with busy already 0.
REQ-025 Latency: start sampled at edge N gives done=1 in the cycle following edge N+33.
REQ-026 A divide with b==0 SHALL skip CALC and FIX and leave HI/LO unchanged.
REQ-027 For b==0, done and div_by_zero SHALL pulse in the cycle after the start edge.
REQ-028 A signed divide 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0, with no flag.
REQ-029 start while busy SHALL be ignored; no queueing.
REQ-030 start in the same cycle that done is high SHALL be accepted, because the state is IDLE.
REQ-031 hi_we/lo_we SHALL write only in IDLE without start.
REQ-032 hi_we/lo_we while busy or together with start SHALL be ignored.
REQ-033 hi_we and lo_we together SHALL write wdata to both registers.
REQ-034 Outputs hi and lo SHALL change only at FIX, on a permitted direct write, or on reset.

Reset
REQ-035 rst SHALL immediately force state=IDLE and busy=0, done=0, div_by_zero=0, hi=0, lo=0.
REQ-036 rst SHALL clear all internal operand, accumulator and counter registers.
REQ-037 rst mid-operation SHALL abort the operation with no done pulse.
REQ-038 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-039 Shared package mdu_pkg SHALL hold the op encoding enum, the state enum and constants WIDTH=32 and STEPS=32.
REQ-040 One combinational sub-module, mdu_step, SHALL implement a single multiply or divide iteration.
REQ-041 All sequencing, counting and HI/LO storage SHALL reside in mdu_seq.

Verification
REQ-042 MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly 33 cycles after start; busy=1 throughout.
REQ-043 MULT 0xFFFFFFFD*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; a new start pulsed on the done cycle is accepted.
REQ-044 DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-045 DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; no div_by_zero.
REQ-046 DIVU 5/0 with HI=0x11, LO=0x22 -> done and div_by_zero one cycle later; HI/LO unchanged.
REQ-047 mtlo 0x1234 in IDLE -> LO=0x1234; mthi while busy -> ignored.
REQ-048 rst at cycle 10 of a MULT -> busy=0, HI=LO=0 immediately, no done pulse.
REQ-049 start issued in the middle of CALC -> ignored; the in-flight result is unaffected.
